// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Latency R/I 4, load 5, store 4, branch 3 cycles plus memory stalls; a stalled access traps after WAIT_LIMIT cycles.
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Counter value seen in the WAIT_LIMIT-th consecutive stalled cycle.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [7:0]       wait_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire, in_wait, limit_hit;

  logic       pc_write_c, ir_write_c, mem_req_c, mem_we_c, iord_c;
  logic       alu_src_a_c, pc_src_c, reg_write_c, mem_to_reg_c, halted_c;
  logic [1:0] alu_src_b_c, alu_op_c;

  assign limit_hit = (wait_q == WAIT_LAST);

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    retire       = 1'b0;
    in_wait      = 1'b0;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    iord_c       = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    pc_src_c     = 1'b0;
    reg_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    halted_c     = 1'b0;
    case (state_q)
      S_FETCH: begin
        in_wait     = 1'b1;
        mem_req_c   = 1'b1;
        alu_src_b_c = 2'b01;
        pc_write_c  = mem_ready;
        ir_write_c  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (limit_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        // Speculative branch target goes into ALUOut while the opcode is decoded.
        alu_src_b_c = 2'b10;
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_ADDR;
          OP_BRANCH: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
              state_d = S_BRANCH;
            end else begin
              state_d = S_TRAP;
              cause_d = 2'b01;
            end
          end
          default: begin
            state_d = S_TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_op_c    = 2'b10;
        state_d     = S_WB_ALU;
      end
      S_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        in_wait   = 1'b1;
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (limit_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_MEM_WR: begin
        in_wait   = 1'b1;
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (limit_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_WB_ALU: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        // Only BEQ/BNE reach here, so funct3[0] alone selects the sense.
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b01;
        pc_src_c    = 1'b1;
        pc_write_c  = funct3[0] ? ~zero : zero;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP: begin
        halted_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cause_q   <= 2'b00;
      wait_q    <= 8'd0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (in_wait && !mem_ready && (state_d == state_q)) begin
        wait_q <= wait_q + 8'd1;
      end else begin
        wait_q <= 8'd0;
      end
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  // Reset gates every control output immediately, ahead of the state update.
  assign pc_write   = pc_write_c   & ~reset;
  assign ir_write   = ir_write_c   & ~reset;
  assign mem_req    = mem_req_c    & ~reset;
  assign mem_we     = mem_we_c     & ~reset;
  assign iord       = iord_c       & ~reset;
  assign alu_src_a  = alu_src_a_c  & ~reset;
  assign alu_src_b  = reset ? 2'b00 : alu_src_b_c;
  assign alu_op     = reset ? 2'b00 : alu_op_c;
  assign pc_src     = pc_src_c     & ~reset;
  assign reg_write  = reg_write_c  & ~reset;
  assign mem_to_reg = mem_to_reg_c & ~reset;
  assign halted     = halted_c     & ~reset;
  assign trap_cause = reset ? 2'b00 : cause_q;
  assign instret    = instret_q;
  assign state_dbg  = state_q;

endmodule
